// File: rtl/cell_store_pkg.sv
// Shared constants, state encoding and default widths for the cell store.
// Optional statistics are enabled with the CELL_STORE_STATS_EN macro.
package cell_store_pkg;

  localparam int unsigned DefAddrW     = 10;
  localparam int unsigned DefDataW     = 64;
  localparam int unsigned DefNumPorts  = 2;
  localparam int unsigned DefHeapBase  = 1;
  localparam int unsigned DefHeapLimit = 127;

  localparam int unsigned NIL_ADDR = 0;

  localparam logic [1:0] FnGetContents = 2'b00;
  localparam logic [1:0] FnSetContents = 2'b01;
  localparam logic [1:0] FnGetFree     = 2'b10;
  localparam logic [1:0] FnQueryFree   = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StReadWait,
    StReadDone,
    StWrite,
    StAlloc,
    StGcWait
  } state_e;

  // Allocation and free-space queries share the single-cycle heap-arithmetic state.
  function automatic state_e op_state(input logic [1:0] fn);
    case (fn)
      FnGetContents: return StReadWait;
      FnSetContents: return StWrite;
      default:       return StAlloc;
    endcase
  endfunction

endpackage

// File: rtl/cell_store_if.sv
// Multi-port client request/response bus of the cell store.
interface cell_store_if
  import cell_store_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned NUM_PORTS = DefNumPorts
);
  logic [NUM_PORTS-1:0]        req_valid;
  logic [2*NUM_PORTS-1:0]      req_func;
  logic [ADDR_W*NUM_PORTS-1:0] req_addr1;
  logic [ADDR_W*NUM_PORTS-1:0] req_addr2;
  logic [DATA_W*NUM_PORTS-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        rsp_valid;
  logic [DATA_W-1:0]           rsp_data1;
  logic [DATA_W-1:0]           rsp_data2;
  logic                        rsp_err;
  logic [ADDR_W-1:0]           free_addr;

  modport master (
    output req_valid, req_func, req_addr1, req_addr2, req_wdata,
    input  req_ready, rsp_valid, rsp_data1, rsp_data2, rsp_err, free_addr
  );

  modport slave (
    input  req_valid, req_func, req_addr1, req_addr2, req_wdata,
    output req_ready, rsp_valid, rsp_data1, rsp_data2, rsp_err, free_addr
  );
endinterface

// File: rtl/cell_ram.sv
// Cell storage: two synchronous read ports, one write port, 1-cycle read latency.
module cell_ram
  import cell_store_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata1 <= mem[raddr1];
    rdata2 <= mem[raddr2];
  end
endmodule

// File: rtl/cell_store.sv
// Arbitrated cell memory with a bump allocator and GC handshake.
// Define CELL_STORE_STATS_EN to build the saturating allocation/GC counters.
module cell_store
  import cell_store_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned NUM_PORTS  = DefNumPorts,
  parameter int unsigned HEAP_BASE  = DefHeapBase,
  parameter int unsigned HEAP_LIMIT = DefHeapLimit
) (
  input  logic              clk,
  input  logic              rst,
  cell_store_if.slave       bus,
  output logic              gc_req,
  input  logic              gc_ack,
  input  logic [ADDR_W-1:0] gc_free_ptr,
  output logic [15:0]       stat_allocs,
  output logic [15:0]       stat_gcs
);
  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef logic [PW-1:0]   port_t;
  typedef logic [ADDR_W:0] cnt_t;

  logic [1:0]        func_arr  [NUM_PORTS];
  logic [ADDR_W-1:0] addr1_arr [NUM_PORTS];
  logic [ADDR_W-1:0] addr2_arr [NUM_PORTS];
  logic [DATA_W-1:0] wdata_arr [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign func_arr[g]  = bus.req_func[2*g +: 2];
    assign addr1_arr[g] = bus.req_addr1[ADDR_W*g +: ADDR_W];
    assign addr2_arr[g] = bus.req_addr2[ADDR_W*g +: ADDR_W];
    assign wdata_arr[g] = bus.req_wdata[DATA_W*g +: DATA_W];
  end

  state_e               state_q, state_d;
  port_t                rr_q, rr_d, port_q, port_d;
  logic [1:0]           func_q, func_d;
  logic [ADDR_W-1:0]    addr1_q, addr1_d, addr2_q, addr2_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 retried_q, retried_d;
  logic [ADDR_W-1:0]    free_ptr_q, free_ptr_d, free_addr_q, free_addr_d;
  logic [NUM_PORTS-1:0] req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d, gc_req_q, gc_req_d;
  logic [DATA_W-1:0]    data1_q, data1_d, data2_q, data2_d;

  // Round-robin search starting at rr_q.
  logic  gnt_found;
  port_t gnt_port, gnt_next;
  logic [PW:0] sum;

  always_comb begin
    gnt_found = 1'b0;
    gnt_port  = '0;
    sum       = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      sum = {1'b0, rr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_PORTS)) sum = sum - (PW+1)'(NUM_PORTS);
      if (!gnt_found && bus.req_valid[sum[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_port  = sum[PW-1:0];
      end
    end
    gnt_next = (gnt_port == port_t'(NUM_PORTS - 1)) ? '0 : gnt_port + 1'b1;
  end

  // Heap arithmetic, all at ADDR_W+1 bits so counts up to 2^ADDR_W are representable.
  cnt_t n, used, query;
  logic too_big, fits, alloc_ok;

  always_comb begin
    n        = wdata_q[ADDR_W:0];
    used     = {1'b0, free_ptr_q} - cnt_t'(HEAP_BASE);
    query    = cnt_t'(HEAP_LIMIT) - used;
    too_big  = n > cnt_t'(HEAP_LIMIT);
    fits     = (n == '0) || (({1'b0, used} + {1'b0, n}) <= (ADDR_W+2)'(HEAP_LIMIT));
    alloc_ok = (state_q == StAlloc) && (func_q == FnGetFree) && !too_big && fits;
  end

  logic [DATA_W-1:0] ram_rdata1, ram_rdata2;
  logic              ram_we;

  // Gating with rst drops an in-flight write atomically.
  assign ram_we = (state_q == StWrite) && !rst;

  cell_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (addr1_q),
    .wdata  (wdata_q),
    .raddr1 (addr1_q),
    .raddr2 (addr2_q),
    .rdata1 (ram_rdata1),
    .rdata2 (ram_rdata2)
  );

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    port_d      = port_q;
    func_d      = func_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    wdata_d     = wdata_q;
    retried_d   = retried_q;
    free_ptr_d  = free_ptr_q;
    free_addr_d = free_addr_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    gc_req_d    = gc_req_q;
    data1_d     = data1_q;
    data2_d     = data2_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          port_d                = gnt_port;
          rr_d                  = gnt_next;
          func_d                = func_arr[gnt_port];
          addr1_d               = addr1_arr[gnt_port];
          addr2_d               = addr2_arr[gnt_port];
          wdata_d               = wdata_arr[gnt_port];
          retried_d             = 1'b0;
          req_ready_d[gnt_port] = 1'b1;
          state_d               = op_state(func_arr[gnt_port]);
        end
      end
      StReadWait: state_d = StReadDone;
      StReadDone: begin
        data1_d             = ram_rdata1;
        data2_d             = ram_rdata2;
        rsp_valid_d[port_q] = 1'b1;
        state_d             = StIdle;
      end
      StWrite: begin
        rsp_valid_d[port_q] = 1'b1;
        state_d             = StIdle;
      end
      StAlloc: begin
        if (func_q == FnQueryFree) begin
          data1_d             = DATA_W'(query);
          rsp_valid_d[port_q] = 1'b1;
          state_d             = StIdle;
        end else if (alloc_ok) begin
          free_addr_d         = free_ptr_q;
          free_ptr_d          = free_ptr_q + n[ADDR_W-1:0];
          rsp_valid_d[port_q] = 1'b1;
          state_d             = StIdle;
        end else if (!too_big && !retried_q) begin
          gc_req_d = 1'b1;
          state_d  = StGcWait;
        end else begin
          rsp_valid_d[port_q] = 1'b1;
          rsp_err_d           = 1'b1;
          state_d             = StIdle;
        end
      end
      StGcWait: begin
        if (gc_ack) begin
          gc_req_d   = 1'b0;
          free_ptr_d = gc_free_ptr;
          retried_d  = 1'b1;
          state_d    = StAlloc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      port_q      <= '0;
      func_q      <= FnGetContents;
      addr1_q     <= '0;
      addr2_q     <= '0;
      wdata_q     <= '0;
      retried_q   <= 1'b0;
      free_ptr_q  <= ADDR_W'(HEAP_BASE);
      free_addr_q <= ADDR_W'(HEAP_BASE);
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      gc_req_q    <= 1'b0;
      data1_q     <= '0;
      data2_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      port_q      <= port_d;
      func_q      <= func_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      wdata_q     <= wdata_d;
      retried_q   <= retried_d;
      free_ptr_q  <= free_ptr_d;
      free_addr_q <= free_addr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      gc_req_q    <= gc_req_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data1 = data1_q;
  assign bus.rsp_data2 = data2_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.free_addr = free_addr_q;
  assign gc_req        = gc_req_q;

`ifdef CELL_STORE_STATS_EN
  logic [15:0] allocs_q, gcs_q;
  logic        gc_hs;

  assign gc_hs = (state_q == StGcWait) && gc_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      allocs_q <= '0;
      gcs_q    <= '0;
    end else begin
      if (alloc_ok && (allocs_q != 16'hFFFF)) allocs_q <= allocs_q + 16'd1;
      if (gc_hs && (gcs_q != 16'hFFFF))       gcs_q    <= gcs_q + 16'd1;
    end
  end

  assign stat_allocs = allocs_q;
  assign stat_gcs    = gcs_q;
`else
  assign stat_allocs = '0;
  assign stat_gcs    = '0;
`endif

endmodule

// File: tb/tb_cell_store.sv
// Directed self-checking bench for cell_store (default build, two ports).
module tb_cell_store;
  import cell_store_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;
  localparam int unsigned NP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          gc_req;
  logic          gc_ack;
  logic [AW-1:0] gc_free_ptr;
  logic [15:0]   stat_allocs, stat_gcs;

  always #5 clk = ~clk;

  cell_store_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_PORTS(NP)) bus ();

  cell_store #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .NUM_PORTS  (NP),
    .HEAP_BASE  (1),
    .HEAP_LIMIT (127)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .gc_req      (gc_req),
    .gc_ack      (gc_ack),
    .gc_free_ptr (gc_free_ptr),
    .stat_allocs (stat_allocs),
    .stat_gcs    (stat_gcs)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [1:0] f, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [DW-1:0] wd);
    bus.req_valid[p]           = 1'b1;
    bus.req_func[2*p +: 2]     = f;
    bus.req_addr1[AW*p +: AW]  = a1;
    bus.req_addr2[AW*p +: AW]  = a2;
    bus.req_wdata[DW*p +: DW]  = wd;
  endtask

  // Present a request and wait (bounded) for its req_ready pulse.
  task automatic issue(input int p, input logic [1:0] f, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [DW-1:0] wd);
    logic got;
    set_req(p, f, a1, a2, wd);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.req_ready[p]) begin
        got = 1'b1;
        break;
      end
    end
    check("req_ready", got, 1'b1);
    bus.req_valid[p] = 1'b0;
  endtask

  // Cycles from req_ready to rsp_valid; 0 on timeout.
  task automatic wait_rsp(input int p, output int lat, output logic saw_gc);
    lat    = 0;
    saw_gc = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      saw_gc |= gc_req;
      if (bus.rsp_valid[p]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wait_gc_req(output logic seen);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (gc_req) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_ack(input logic [AW-1:0] fp);
    gc_free_ptr = fp;
    gc_ack      = 1'b1;
    @(posedge clk);
    #1;
    gc_ack      = 1'b0;
  endtask

  int   lat;
  logic saw_gc, seen, any;
  int   grants [4];
  int   ng;

  initial begin
    rst           = 1'b1;
    gc_ack        = 1'b0;
    gc_free_ptr   = '0;
    bus.req_valid = '0;
    bus.req_func  = '0;
    bus.req_addr1 = '0;
    bus.req_addr2 = '0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_free_addr", bus.free_addr, 1);
    check("rst_data1", bus.rsp_data1, 0);
    check("rst_data2", bus.rsp_data2, 0);
    check("rst_gc_req", gc_req, 0);
    check("rst_stats", {stat_allocs, stat_gcs}, 0);
    rst = 1'b0;

    // Writes and the two-port read
    issue(0, FnSetContents, 0, 0, 64'h1234);
    wait_rsp(0, lat, saw_gc);
    check("set0_lat", lat, 1);
    issue(0, FnSetContents, 5, 0, 64'hDEAD);
    wait_rsp(0, lat, saw_gc);
    check("set5_lat", lat, 1);
    check("set5_err", bus.rsp_err, 0);
    issue(1, FnGetContents, 5, 0, 0);
    wait_rsp(1, lat, saw_gc);
    check("get_lat", lat, 2);
    check("get_data1", bus.rsp_data1, 64'hDEAD);
    check("get_data2", bus.rsp_data2, 64'h1234);
    issue(1, FnSetContents, 7, 0, 64'h77);
    wait_rsp(1, lat, saw_gc);
    check("hold_data1", bus.rsp_data1, 64'hDEAD);

    // Both ports request continuously; last grant was port 1 so port 0 goes first
    for (int i = 0; i < 4; i++) grants[i] = 9;
    ng = 0;
    set_req(0, FnSetContents, 10, 0, 64'hA0);
    set_req(1, FnSetContents, 11, 0, 64'hB1);
    for (int k = 0; k < 40 && ng < 4; k++) begin
      @(posedge clk);
      #1;
      if (bus.req_ready[0]) grants[ng++] = 0;
      else if (bus.req_ready[1]) grants[ng++] = 1;
    end
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), grants[i], i % 2);
    repeat (4) @(posedge clk);
    #1;
    issue(0, FnGetContents, 10, 11, 0);
    wait_rsp(0, lat, saw_gc);
    check("rr_mem10", bus.rsp_data1, 64'hA0);
    check("rr_mem11", bus.rsp_data2, 64'hB1);

    // Bump allocation
    issue(0, FnGetFree, 0, 0, 100);
    wait_rsp(0, lat, saw_gc);
    check("alloc100_lat", lat, 1);
    check("alloc100_err", bus.rsp_err, 0);
    check("alloc100_addr", bus.free_addr, 1);
    issue(1, FnGetFree, 0, 0, 20);
    wait_rsp(1, lat, saw_gc);
    check("alloc20_addr", bus.free_addr, 101);
    issue(0, FnQueryFree, 0, 0, 0);
    wait_rsp(0, lat, saw_gc);
    check("query_lat", lat, 1);
    check("query7", bus.rsp_data1, 7);
    issue(0, FnGetFree, 0, 0, 0);
    wait_rsp(0, lat, saw_gc);
    check("alloc0_err", bus.rsp_err, 0);
    check("alloc0_addr", bus.free_addr, 121);
    issue(1, FnQueryFree, 0, 0, 0);
    wait_rsp(1, lat, saw_gc);
    check("query7_again", bus.rsp_data1, 7);

    // Out of space: GC reclaims down to 30, retry succeeds
    issue(0, FnGetFree, 0, 0, 10);
    wait_gc_req(seen);
    check("gc_req_set", seen, 1);
    any = bus.rsp_valid[0];
    repeat (3) begin
      @(posedge clk);
      #1;
      any |= bus.rsp_valid[0];
    end
    check("gc_req_held", gc_req, 1);
    check("gc_no_rsp", any, 0);
    pulse_ack(30);
    check("gc_req_drop", gc_req, 0);
    wait_rsp(0, lat, saw_gc);
    check("gc_retry_lat", lat, 1);
    check("gc_retry_err", bus.rsp_err, 0);
    check("gc_retry_addr", bus.free_addr, 30);
`ifdef CELL_STORE_STATS_EN
    check("stat_allocs", stat_allocs, 4);
    check("stat_gcs", stat_gcs, 1);
`else
    check("stat_allocs", stat_allocs, 0);
    check("stat_gcs", stat_gcs, 0);
`endif
    issue(0, FnQueryFree, 0, 0, 0);
    wait_rsp(0, lat, saw_gc);
    check("query88", bus.rsp_data1, 88);

    // GC does not free enough: error, pointer keeps the GC value
    issue(1, FnGetFree, 0, 0, 90);
    wait_gc_req(seen);
    check("gc2_req_set", seen, 1);
    pulse_ack(125);
    wait_rsp(1, lat, saw_gc);
    check("gc2_lat", lat, 1);
    check("gc2_err", bus.rsp_err, 1);
    check("gc2_addr", bus.free_addr, 30);
    issue(1, FnQueryFree, 0, 0, 0);
    wait_rsp(1, lat, saw_gc);
    check("query3", bus.rsp_data1, 3);

    // Oversized request fails at once without GC
    issue(0, FnGetFree, 0, 0, 200);
    wait_rsp(0, lat, saw_gc);
    check("big_lat", lat, 1);
    check("big_err", bus.rsp_err, 1);
    check("big_no_gc", saw_gc, 0);

    // Reset while waiting for GC
    issue(0, FnGetFree, 0, 0, 10);
    wait_gc_req(seen);
    check("gc3_req_set", seen, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_gc_req_drop", gc_req, 0);
    any = |bus.rsp_valid;
    repeat (4) begin
      @(posedge clk);
      #1;
      any |= (|bus.rsp_valid) | gc_req;
    end
    check("rst_abandon", any, 0);
    check("rst2_free_addr", bus.free_addr, 1);
    issue(1, FnQueryFree, 0, 0, 0);
    wait_rsp(1, lat, saw_gc);
    check("rst2_query127", bus.rsp_data1, 127);
    issue(1, FnGetContents, 5, 0, 0);
    wait_rsp(1, lat, saw_gc);
    check("keep_mem5", bus.rsp_data1, 64'hDEAD);
    check("keep_mem0", bus.rsp_data2, 64'h1234);

    // Stray gc_ack while idle must not move the free pointer
    pulse_ack(50);
    issue(0, FnQueryFree, 0, 0, 0);
    wait_rsp(0, lat, saw_gc);
    check("stray_ack_query", bus.rsp_data1, 127);
    check("stray_ack_gc_req", gc_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cell_store.md
CELL_STORE -- requirements
Module: cell_store

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, cell address width.
REQ-002 SHALL have parameter DATA_W, default 64, cell word width.
REQ-003 SHALL have parameter NUM_PORTS, default 2, number of client request ports (1..8).
REQ-004 SHALL have parameter HEAP_BASE, default 1, first allocatable address (address 0 is NIL).
REQ-005 SHALL have parameter HEAP_LIMIT, default 127, maximum cells allocatable before GC.
REQ-006 SHALL have ports: clk  in  1  single clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: req_valid  in  NUM_PORTS  request pending per port; req_func  in  2*NUM_PORTS  opcode per port; req_addr1, req_addr2  in  ADDR_W*NUM_PORTS  operand addresses per port; req_wdata  in  DATA_W*NUM_PORTS  write data or alloc count per port.
REQ-008 SHALL have ports: req_ready  out  NUM_PORTS  one-cycle accept pulse; rsp_valid  out  NUM_PORTS  one-cycle completion pulse; rsp_data1, rsp_data2  out  DATA_W  shared read results; rsp_err  out  1  failure flag, qualified by rsp_valid; free_addr  out  ADDR_W  base of last granted block.
REQ-009 SHALL have ports: gc_req  out  1  collection request level; gc_ack  in  1  collection done pulse; gc_free_ptr  in  ADDR_W  post-GC free pointer; stat_allocs, stat_gcs  out  16  statistics counters.

Function
REQ-010 SHALL use opcodes 00 GET_CONTENTS, 01 SET_CONTENTS, 10 GET_FREE, 11 QUERY_FREE.
REQ-011 SHALL keep exactly one operation in flight; states IDLE, READ_WAIT, READ_DONE, WRITE, ALLOC, GC_WAIT.
REQ-012 SHALL arbitrate in IDLE round-robin among asserted req_valid, starting from the port after the last granted port; port 0 has priority after reset.
REQ-013 SHALL pulse req_ready for the granted port in the cycle it leaves IDLE; clients hold req_valid and operands stable until req_ready.
REQ-014 GET_CONTENTS SHALL return mem[addr1] on rsp_data1 and mem[addr2] on rsp_data2 with rsp_valid 2 cycles after req_ready.
REQ-015 SHALL write req_wdata to mem[addr1] in SET_CONTENTS and pulse rsp_valid 1 cycle after req_ready.
REQ-016 GET_FREE with count n (low ADDR_W+1 bits of wdata) SHALL compute used = free_ptr - HEAP_BASE at ADDR_W+1 bits; if used+n <= HEAP_LIMIT, free_addr <= free_ptr, free_ptr += n, rsp_valid 1 cycle after req_ready, rsp_err 0.
REQ-017 If allocation does not fit, SHALL enter GC_WAIT, assert gc_req until gc_ack, load free_ptr from gc_free_ptr, then retry once; if retry fails, rsp_valid with rsp_err 1 and free_ptr unchanged.
REQ-018 n > HEAP_LIMIT SHALL return rsp_err 1 immediately without GC; n = 0 SHALL return free_addr = free_ptr with no change.
REQ-019 QUERY_FREE SHALL return HEAP_LIMIT - used on rsp_data1 (zero-extended) 1 cycle after req_ready.
REQ-020 gc_ack outside GC_WAIT SHALL be ignored; requests arriving during GC_WAIT SHALL wait without req_ready.
REQ-021 rsp_data1/rsp_data2 SHALL hold their values until the next read or QUERY_FREE completes.

Reset
REQ-022 rst SHALL set state IDLE, free_ptr = HEAP_BASE, free_addr = HEAP_BASE, round-robin pointer to 0, and req_ready, rsp_valid, rsp_err, gc_req, rsp_data1, rsp_data2 and the stat counters to 0.
REQ-023 rst during any operation SHALL abandon it with no response pulse; a write in progress completes or is dropped atomically; memory contents are not cleared.

Configuration
REQ-024 With CELL_STORE_STATS_EN defined, stat_allocs SHALL count successful GET_FREE and stat_gcs SHALL count gc_ack handshakes, both saturating at 0xFFFF; without it, both outputs SHALL be tied to 0 and no counter logic exists.

Structure
REQ-025 Opcode constants, NIL_ADDR, the state encoding and the default widths SHALL live in the shared package cell_store_pkg.
REQ-026 Storage SHALL be the sub-module cell_ram: 2 synchronous read ports, 1 write port, 1-cycle read latency, 2^ADDR_W words.

Verification
REQ-027 SET mem[5] = 0xDEAD, then GET addr1 = 5, addr2 = 0 -> rsp_data1 = 0xDEAD, rsp_data2 = mem[0], rsp_valid 2 cycles after req_ready.
REQ-028 Both ports request every cycle -> grants alternate 0, 1, 0, 1; no port is starved.
REQ-029 GET_FREE 100, then GET_FREE 20 -> free_addr 1, then 101; QUERY_FREE -> 7.
REQ-030 GET_FREE 10 with used = 120 -> gc_req held; gc_ack with gc_free_ptr = 30 -> free_addr 30, rsp_err 0; if gc_free_ptr = 125 -> rsp_err 1.
REQ-031 GET_FREE 200 -> rsp_err 1, gc_req never asserted; rst during GC_WAIT -> gc_req 0 next cycle, no rsp_valid.
